// File: rtl/pipeline_ctrl.sv
// Hazard and memory-stall control for a five-stage RISC-V pipeline.
// Generates stall/flush/enable, ALU forwarding and a saturating stall counter.
module pipeline_ctrl #(
  parameter int REGISTER_ADDRESS_WIDTH = 5,
  parameter int CNT_WIDTH              = 16,
  parameter int TIMEOUT                = 255
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs1D_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs2D_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs1E_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs2E_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] RdE_i,
  input  logic [1:0]                        ResultSrcE_i,
  input  logic                              PCSrcE_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] RdM_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] RdW_i,
  input  logic                              RegWriteM_i,
  input  logic                              RegWriteW_i,
  input  logic                              MemReqM_i,
  input  logic                              MemReadyM_i,
  output logic                              StallF_o,
  output logic                              StallD_o,
  output logic                              FlushD_o,
  output logic                              FlushE_o,
  output logic                              FlushW_o,
  output logic                              EnE_o,
  output logic                              EnM_o,
  output logic [1:0]                        ForwardAE_o,
  output logic [1:0]                        ForwardBE_o,
  output logic [CNT_WIDTH-1:0]              StallCount_o,
  output logic                              Busy_o,
  output logic                              Error_o
);

  localparam int WW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] TO = WW'(TIMEOUT);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_e;

  state_e              state_q;
  logic [WW-1:0]       wait_q;
  logic [CNT_WIDTH-1:0] cnt_q;

  logic mem_stall;
  logic lw_stall;

  assign mem_stall = (state_q == RUN && MemReqM_i && !MemReadyM_i)
                   | (state_q == MEM_WAIT && !MemReadyM_i)
                   | (state_q == ERROR);

  assign lw_stall = (ResultSrcE_i == 2'b01) && (RdE_i != '0)
                 && ((RdE_i == Rs1D_i) || (RdE_i == Rs2D_i));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RUN;
      wait_q  <= '0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (MemReqM_i && !MemReadyM_i) begin
            state_q <= MEM_WAIT;
            wait_q  <= '0;
          end
        end
        MEM_WAIT: begin
          if (MemReadyM_i) begin
            state_q <= RUN;
          end else if (wait_q == TO) begin
            state_q <= ERROR;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        ERROR: state_q <= ERROR;
        default: state_q <= RUN;
      endcase
    end
  end

  // Saturating: holds at all-ones instead of wrapping.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if ((mem_stall || lw_stall) && cnt_q != '1) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // A memory freeze wins over any flush request.
  always_comb begin
    if (mem_stall) begin
      StallF_o = 1'b1;
      StallD_o = 1'b1;
      EnE_o    = 1'b0;
      EnM_o    = 1'b0;
      FlushW_o = 1'b1;
      FlushD_o = 1'b0;
      FlushE_o = 1'b0;
    end else begin
      StallF_o = lw_stall;
      StallD_o = lw_stall;
      EnE_o    = 1'b1;
      EnM_o    = 1'b1;
      FlushW_o = 1'b0;
      FlushD_o = PCSrcE_i;
      FlushE_o = lw_stall | PCSrcE_i;
    end
  end

  logic hit_ma, hit_wa, hit_mb, hit_wb;

  assign hit_ma = RegWriteM_i && RdM_i != '0 && RdM_i == Rs1E_i;
  assign hit_wa = RegWriteW_i && RdW_i != '0 && RdW_i == Rs1E_i;
  assign hit_mb = RegWriteM_i && RdM_i != '0 && RdM_i == Rs2E_i;
  assign hit_wb = RegWriteW_i && RdW_i != '0 && RdW_i == Rs2E_i;

  always_comb begin
    ForwardAE_o = 2'b00;
    priority case (1'b1)
      hit_ma:  ForwardAE_o = 2'b10;
      hit_wa:  ForwardAE_o = 2'b01;
      default: ForwardAE_o = 2'b00;
    endcase
  end

  always_comb begin
    ForwardBE_o = 2'b00;
    priority case (1'b1)
      hit_mb:  ForwardBE_o = 2'b10;
      hit_wb:  ForwardBE_o = 2'b01;
      default: ForwardBE_o = 2'b00;
    endcase
  end

  assign StallCount_o = cnt_q;
  assign Busy_o       = (state_q == MEM_WAIT);
  assign Error_o      = (state_q == ERROR);

endmodule
